and_chain_driver: RTL and testbench

Self-checking stimulus sequencer for the 8-input AND-chain timing netlist. It drives the chain inputs IN1..IN8 from registers and steps through every input pattern. After a programmable settle time it samples the chain output OUT and compares it with the expected AND of the inputs. It counts mismatches and records the first failing pattern. The block sits on the input side of the chain and also receives its output, so it closes the loop for silicon or gate-level bring-up.

---
 rtl/and_chain_driver_if.sv | 27 ++
 rtl/and_chain_driver.sv | 114 +++++++++++
 tb/tb_and_chain_driver.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/and_chain_driver_if.sv
// Bus between the AND-chain sequencer and whoever drives and observes it:
// sweep control, the chain drive/return, and the sweep result.
interface and_chain_driver_if #(
  parameter int N_IN = 8
);
  logic            i_start;
  logic            i_abort;
  logic            i_out_sample;
  logic [N_IN-1:0] o_in_vec;
  logic            o_busy;
  logic            o_done;
  logic            o_pass;
  logic [7:0]      o_err_count;
  logic [N_IN-1:0] o_first_fail;

  // Sequencer side
  modport slave (
    input  i_start, i_abort, i_out_sample,
    output o_in_vec, o_busy, o_done, o_pass, o_err_count, o_first_fail
  );

  // Controller / chain-model side
  modport master (
    output i_start, i_abort, i_out_sample,
    input  o_in_vec, o_busy, o_done, o_pass, o_err_count, o_first_fail
  );
endinterface

// File: rtl/and_chain_driver.sv
// Exhaustive stimulus sequencer for an N_IN-input AND chain. Walks in_vec
// through every pattern, holds each one for SETTLE cycles, then compares
// the chain output with &in_vec. Counts mismatches (saturating) and
// records the first failing pattern.
module and_chain_driver #(
  parameter int N_IN   = 8,
  parameter int SETTLE = 4
) (
  input logic             clk,
  input logic             rst,
  and_chain_driver_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

  localparam logic [7:0]      SETTLE_V = 8'(SETTLE);
  localparam logic [N_IN-1:0] ONE_V    = N_IN'(1);

  state_t          r_state, w_state_nxt;
  logic [N_IN-1:0] r_vec, w_vec_nxt;
  logic [7:0]      r_timer, w_timer_nxt;
  logic [7:0]      r_err, w_err_nxt;
  logic [N_IN-1:0] r_ff, w_ff_nxt;
  logic            r_pass, w_pass_nxt;
  logic            r_first, w_first_nxt;   // no mismatch seen yet this sweep

  logic            w_mis;
  logic [7:0]      w_err_upd;

  assign w_mis     = ((&r_vec) != bus.i_out_sample);
  assign w_err_upd = (w_mis && (r_err != 8'hFF)) ? r_err + 8'd1 : r_err;

  // State and datapath registers; everything is registered so the chain
  // drive only moves on a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_vec   <= '0;
      r_timer <= '0;
      r_err   <= '0;
      r_ff    <= '0;
      r_pass  <= 1'b0;
      r_first <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_vec   <= w_vec_nxt;
      r_timer <= w_timer_nxt;
      r_err   <= w_err_nxt;
      r_ff    <= w_ff_nxt;
      r_pass  <= w_pass_nxt;
      r_first <= w_first_nxt;
    end
  end

  // Next-state and next-datapath logic; abort overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_timer_nxt = r_timer;
    w_err_nxt   = r_err;
    w_ff_nxt    = r_ff;
    w_pass_nxt  = r_pass;
    w_first_nxt = r_first;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_vec_nxt   = '0;
          w_err_nxt   = '0;
          w_ff_nxt    = '0;
          w_pass_nxt  = 1'b0;
          w_first_nxt = 1'b1;
          w_timer_nxt = SETTLE_V;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_timer_nxt = r_timer - 8'd1;
        if (r_timer == 8'd1) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        w_err_nxt = w_err_upd;
        if (w_mis && r_first) begin
          w_ff_nxt    = r_vec;
          w_first_nxt = 1'b0;
        end
        if (&r_vec) begin
          w_pass_nxt  = (w_err_upd == 8'd0);
          w_state_nxt = S_DONE;
        end else begin
          w_vec_nxt   = r_vec + ONE_V;
          w_timer_nxt = SETTLE_V;
          w_state_nxt = S_WAIT;
        end
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.i_abort) begin
      w_state_nxt = S_IDLE;
      w_vec_nxt   = '0;
      w_timer_nxt = '0;
      w_pass_nxt  = 1'b0;
      w_err_nxt   = r_err;
      w_ff_nxt    = r_ff;
      w_first_nxt = r_first;
    end
  end

  assign bus.o_in_vec     = r_vec;
  assign bus.o_busy       = (r_state == S_WAIT) || (r_state == S_CHECK);
  assign bus.o_done       = (r_state == S_DONE);
  assign bus.o_pass       = r_pass;
  assign bus.o_err_count  = r_err;
  assign bus.o_first_fail = r_ff;
endmodule

// File: tb/tb_and_chain_driver.sv
// Bench for and_chain_driver: three instances (SETTLE 4, 1, 3) with
// behavioural chain models; expected sweep results are queued at start and
// checked when done pulses.
module tb_and_chain_driver;
  logic clk = 1'b0;
  logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
  int   cyc = 0;
  int   mode = 0;               // dut0 chain model: 0 ideal, 1 stuck-0, 2 inverted
  int   n_pass = 0, n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  and_chain_driver_if #(.N_IN(8)) if0 ();
  and_chain_driver_if #(.N_IN(8)) if1 ();
  and_chain_driver_if #(.N_IN(8)) if2 ();

  and_chain_driver #(.N_IN(8), .SETTLE(4)) dut0 (.clk(clk), .rst(rst0), .bus(if0));
  and_chain_driver #(.N_IN(8), .SETTLE(1)) dut1 (.clk(clk), .rst(rst1), .bus(if1));
  and_chain_driver #(.N_IN(8), .SETTLE(3)) dut2 (.clk(clk), .rst(rst2), .bus(if2));

  // Chain models
  assign if0.i_out_sample = (mode == 0) ? (&if0.o_in_vec) :
                            (mode == 1) ? 1'b0 : ~(&if0.o_in_vec);
  logic d1a = 1'b0, d2a = 1'b0, d1b = 1'b0, d2b = 1'b0;
  always @(posedge clk) begin
    d1a <= &if1.o_in_vec; d2a <= d1a;
    d1b <= &if2.o_in_vec; d2b <= d1b;
  end
  assign if1.i_out_sample = d2a;
  assign if2.i_out_sample = d2b;

  typedef struct {
    string      tag;
    int         dut;
    logic [7:0] err;
    logic [7:0] ff;
    logic       pass;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  function automatic int settle_of(int d);
    return (d == 0) ? 4 : (d == 1) ? 1 : 3;
  endfunction
  function automatic logic [7:0] g_vec(int d);
    return (d == 0) ? if0.o_in_vec : (d == 1) ? if1.o_in_vec : if2.o_in_vec;
  endfunction
  function automatic logic g_busy(int d);
    return (d == 0) ? if0.o_busy : (d == 1) ? if1.o_busy : if2.o_busy;
  endfunction
  function automatic logic g_done(int d);
    return (d == 0) ? if0.o_done : (d == 1) ? if1.o_done : if2.o_done;
  endfunction
  function automatic logic g_pass(int d);
    return (d == 0) ? if0.o_pass : (d == 1) ? if1.o_pass : if2.o_pass;
  endfunction
  function automatic logic [7:0] g_err(int d);
    return (d == 0) ? if0.o_err_count : (d == 1) ? if1.o_err_count : if2.o_err_count;
  endfunction
  function automatic logic [7:0] g_ff(int d);
    return (d == 0) ? if0.o_first_fail : (d == 1) ? if1.o_first_fail : if2.o_first_fail;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_start(input int d, input logic v);
    case (d)
      0: if0.i_start = v;
      1: if1.i_start = v;
      default: if2.i_start = v;
    endcase
  endtask

  // Pulse start at the next edge; optionally queue the expected sweep result.
  task automatic do_start(input int d, input bit push, input string tag,
                          input logic [7:0] err, input logic [7:0] ff, input logic pass);
    exp_t e;
    @(negedge clk);
    set_start(d, 1'b1);
    if (push) begin
      e.tag = tag; e.dut = d; e.err = err; e.ff = ff; e.pass = pass;
      e.cyc = (cyc + 1) + 256 * (settle_of(d) + 1) + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    set_start(d, 1'b0);
  endtask

  // Wait (bounded) for done on dut d, then pop and compare the scoreboard.
  task automatic wait_done(input int d, input int budget);
    exp_t e;
    bit   seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (g_done(d)) begin seen = 1; break; end
      @(negedge clk);
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "_done_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    chk({e.tag, "_done_cycle"}, 32'(cyc + 1), 32'(e.cyc));
    chk({e.tag, "_err"},  32'(g_err(d)),  32'(e.err));
    chk({e.tag, "_ff"},   32'(g_ff(d)),   32'(e.ff));
    chk({e.tag, "_pass"}, 32'(g_pass(d)), 32'(e.pass));
    chk({e.tag, "_busy_low_in_done"}, 32'(g_busy(d)), 32'd0);
    @(negedge clk);
    chk({e.tag, "_done_one_cycle"}, 32'(g_done(d)), 32'd0);
    chk({e.tag, "_vec_hold"}, 32'(g_vec(d)), 32'hFF);
  endtask

  task automatic wait_vec(input int d, input logic [7:0] v, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (g_vec(d) == v) begin seen = 1; break; end
    end
    chk($sformatf("wait_vec_%0h", v), 32'(seen), 32'd1);
  endtask

  initial begin
    int cnt_busy, cnt_done;
    if0.i_start = 0; if0.i_abort = 0;
    if1.i_start = 0; if1.i_abort = 0;
    if2.i_start = 0; if2.i_abort = 0;
    #1;
    chk("rst_vec",  32'(if0.o_in_vec), 32'd0);
    chk("rst_busy", 32'(if0.o_busy), 32'd0);
    chk("rst_done", 32'(if0.o_done), 32'd0);
    chk("rst_pass", 32'(if0.o_pass), 32'd0);
    chk("rst_err",  32'(if0.o_err_count), 32'd0);
    chk("rst_ff",   32'(if0.o_first_fail), 32'd0);
    @(negedge clk); @(negedge clk);
    rst0 = 0; rst1 = 0; rst2 = 0;

    // Ideal chain: start sampled at edge 10, done in cycle 1291
    while (cyc < 8) @(negedge clk);
    mode = 0;
    do_start(0, 1, "ideal", 8'd0, 8'h00, 1'b1);
    chk("ideal_busy_after_start", 32'(if0.o_busy), 32'd1);
    chk("ideal_vec_after_start", 32'(if0.o_in_vec), 32'd0);
    chk("ideal_exp_cycle", 32'(sb[0].cyc), 32'd1291);
    wait_done(0, 2000);
    repeat (3) @(negedge clk);
    chk("ideal_pass_holds", 32'(if0.o_pass), 32'd1);

    mode = 1;
    do_start(0, 1, "stuck0", 8'd1, 8'hFF, 1'b0);
    chk("stuck0_pass_cleared", 32'(if0.o_pass), 32'd0);
    wait_done(0, 2000);

    mode = 2;
    do_start(0, 1, "invert", 8'd255, 8'h00, 1'b0);
    wait_done(0, 2000);

    do_start(1, 1, "dly_s1", 8'd1, 8'hFF, 1'b0);
    wait_done(1, 1000);
    do_start(2, 1, "dly_s3", 8'd0, 8'h00, 1'b1);
    wait_done(2, 1500);

    // Abort mid-WAIT at 0x40, with a start pulse during the run ignored
    mode = 2;
    do_start(0, 0, "", 8'd0, 8'd0, 1'b0);
    wait_vec(0, 8'h20, 400);
    set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    chk("busy_start_ignored_vec", 32'(if0.o_in_vec), 32'h20);
    chk("busy_start_ignored_busy", 32'(if0.o_busy), 32'd1);
    wait_vec(0, 8'h40, 400);
    if0.i_abort = 1;
    @(negedge clk);
    if0.i_abort = 0;
    chk("abort_busy", 32'(if0.o_busy), 32'd0);
    chk("abort_vec",  32'(if0.o_in_vec), 32'd0);
    chk("abort_done", 32'(if0.o_done), 32'd0);
    chk("abort_pass", 32'(if0.o_pass), 32'd0);
    chk("abort_err_hold", 32'(if0.o_err_count), 32'd64);
    chk("abort_ff_hold",  32'(if0.o_first_fail), 32'd0);
    cnt_busy = 0; cnt_done = 0;
    repeat (30) begin
      @(negedge clk);
      cnt_busy += int'(if0.o_busy);
      cnt_done += int'(if0.o_done);
    end
    chk("abort_no_restart", 32'(cnt_busy), 32'd0);
    chk("abort_no_done", 32'(cnt_done), 32'd0);

    // Reset mid-sweep at 0x80, then a fresh full sweep
    mode = 0;
    do_start(0, 0, "", 8'd0, 8'd0, 1'b0);
    wait_vec(0, 8'h80, 1000);
    rst0 = 1;
    #1;
    chk("mrst_vec",  32'(if0.o_in_vec), 32'd0);
    chk("mrst_busy", 32'(if0.o_busy), 32'd0);
    chk("mrst_done", 32'(if0.o_done), 32'd0);
    chk("mrst_err",  32'(if0.o_err_count), 32'd0);
    chk("mrst_ff",   32'(if0.o_first_fail), 32'd0);
    @(negedge clk);
    rst0 = 0;
    @(negedge clk);
    chk("mrst_stays_idle", 32'(if0.o_busy), 32'd0);
    do_start(0, 1, "after_rst", 8'd0, 8'h00, 1'b1);
    wait_done(0, 2000);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
